aurora_block_framer: RTL

AURORA_BLOCK_FRAMER -- requirements
Module: aurora_block_framer

---
 rtl/aurora_pkg.sv | 47 ++++
 rtl/aurora_cc_timer.sv | 43 ++++
 rtl/aurora_block_framer.sv | 96 +++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// Shared constants, state type and block encoder for the Aurora 64b/66b
// block framer.
package aurora_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE = 8'h78;
    localparam logic [7:0] BT_SEP  = 8'h1E;
    localparam logic [7:0] BT_SEP7 = 8'hE1;

    localparam logic [7:0] FLAG_NR = 8'h20;
    localparam logic [7:0] FLAG_CC = 8'h80;

    localparam logic [3:0] FULL_DATA = 4'h8;

    localparam logic [65:0] IDLE_BLK    = {SYNC_CTRL, BT_IDLE, 56'h0};
    localparam logic [65:0] NR_IDLE_BLK = {SYNC_CTRL, BT_IDLE, FLAG_NR, 48'h0};
    localparam logic [65:0] CC_BLK      = {SYNC_CTRL, BT_IDLE, FLAG_CC, 48'h0};

    typedef enum logic [1:0] {
        ST_NOT_READY = 2'd0,
        ST_RUN       = 2'd1,
        ST_CC        = 2'd2
    } framer_state_t;

    // Invalid counts (9..15) map to a plain idle block.
    function automatic logic [65:0] encode_block(
        input logic [63:0] data,
        input logic [3:0]  bytes
    );
        logic [47:0] kept;
        kept = '0;
        for (int i = 0; i < 6; i++) begin
            if (4'(i) < bytes) kept[8*i +: 8] = data[8*i +: 8];
        end
        if (bytes == FULL_DATA)
            return {SYNC_DATA, data};
        else if (bytes == 4'd7)
            return {SYNC_CTRL, BT_SEP7, data[55:0]};
        else if (bytes < 4'd7)
            return {SYNC_CTRL, BT_SEP, {4'h0, bytes}, kept};
        else
            return IDLE_BLK;
    endfunction

endpackage

// File: rtl/aurora_cc_timer.sv
// Clock-compensation scheduler: counts RUN blocks up to CC_PERIOD and
// CC blocks up to CC_LENGTH per burst.
module aurora_cc_timer #(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LENGTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run_tick,
    input  logic cc_tick,
    output logic expire,
    output logic burst_done
);

    localparam int PW = $clog2(CC_PERIOD + 1);
    localparam int BW = $clog2(CC_LENGTH + 1);

    logic [PW-1:0] period_cnt;
    logic [BW-1:0] burst_cnt;

    assign expire     = (period_cnt == PW'(CC_PERIOD - 1));
    assign burst_done = (burst_cnt == BW'(CC_LENGTH - 1));

    // Period count parks at terminal during the burst and reloads on exit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            period_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            if (run_tick && !expire) period_cnt <= period_cnt + PW'(1);
            if (cc_tick) begin
                if (burst_done) begin
                    burst_cnt  <= '0;
                    period_cnt <= '0;
                end else begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/aurora_block_framer.sv
// Aurora 64b/66b block framer with payload handshake and idle generation.
// Clock-compensation bursts are built only when AURORA_CC_EN is defined.
module aurora_block_framer
    import aurora_pkg::*;
#(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LENGTH = 3
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        LaneReady,
    input  logic [63:0] DataToSend,
    input  logic [3:0]  BytesToSend,
    input  logic        SendBlock,
    output logic        BlockSent,
    input  logic        TxReady,
    output logic [65:0] BlockOut,
    output logic        ErrInvalidBytes
);

    framer_state_t state, state_nxt;
    logic [65:0]   block_nxt;
    logic          accept;

`ifdef AURORA_CC_EN
    logic cc_expire;
    logic cc_done;

    aurora_cc_timer #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LENGTH (CC_LENGTH)
    ) u_cc_timer (
        .clk        (Clk),
        .rst        (Rst),
        .clear      (state == ST_NOT_READY),
        .run_tick   (state == ST_RUN && TxReady),
        .cc_tick    (state == ST_CC && TxReady),
        .expire     (cc_expire),
        .burst_done (cc_done)
    );
`endif

    always_comb begin
        state_nxt = state;
        block_nxt = BlockOut;
        accept    = 1'b0;
        unique case (state)
            ST_NOT_READY: begin
                if (TxReady) block_nxt = NR_IDLE_BLK;
                if (LaneReady) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (TxReady) begin
`ifdef AURORA_CC_EN
                    // Expiry beats a pending payload; it waits out the burst.
                    if (cc_expire) begin
                        block_nxt = IDLE_BLK;
                        state_nxt = ST_CC;
                    end else
`endif
                    if (SendBlock && !BlockSent) begin
                        accept    = 1'b1;
                        block_nxt = encode_block(DataToSend, BytesToSend);
                    end else begin
                        block_nxt = IDLE_BLK;
                    end
                end
            end
`ifdef AURORA_CC_EN
            ST_CC: begin
                if (TxReady) begin
                    block_nxt = CC_BLK;
                    if (cc_done) state_nxt = ST_RUN;
                end
            end
`endif
            default: state_nxt = ST_NOT_READY;
        endcase
        if (!LaneReady) state_nxt = ST_NOT_READY;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= ST_NOT_READY;
            BlockOut        <= NR_IDLE_BLK;
            BlockSent       <= 1'b0;
            ErrInvalidBytes <= 1'b0;
        end else begin
            state     <= state_nxt;
            BlockOut  <= block_nxt;
            BlockSent <= accept;
            if (accept && BytesToSend > FULL_DATA) ErrInvalidBytes <= 1'b1;
        end
    end

endmodule
